stage_cmd_sequencer: RTL and testbench
======================================

Name: stage_cmd_sequencer

Overview:
Queued stage-command issuer for the EKF-SLAM accelerator top. It buffers up to DEPTH stage commands (PRD/NEW/UPD/ASSOC), each with its per-stage operands (l_k, vlr, alpha, rk, phi). It issues one command at a time as a stage_val pulse with stable operands, then waits for the matching stage_rdy completion. It adds a completion watchdog, illegal-code rejection and flush, and replaces hand-timed stage_val sequencing.

Parameters:
RSA_DW, 32, operand data width (vlr, rk)
RSA_AW, 17, angle width (alpha, phi)
ROW_LEN, 10, landmark index width (l_k)
DEPTH, 8, command FIFO entries (power of 2, ≥2)
PULSE_LEN, 2, cycles stage_val is held per issue (≥1)
TO_W, 16, watchdog counter width

Ports:
clk  in  1  clock, rising edge
sys_rst  in  1  synchronous active-low reset (0 = reset)
cmd_val  in  1  command push valid
cmd_rdy  out  1  FIFO can accept (count < DEPTH)
cmd_stage  in  3  stage code: 1 PRD, 2 NEW, 3 UPD, 4 ASSOC
cmd_l_k  in  ROW_LEN  landmark index
cmd_vlr  in  RSA_DW  velocity operand
cmd_alpha  in  RSA_AW  steering angle
cmd_rk  in  RSA_DW  range observation
cmd_phi  in  RSA_AW  bearing observation
flush  in  1  drop queue, abort wait, clear errors
to_lim  in  TO_W  watchdog limit in cycles; 0 disables
stage_val  out  3  stage code to accelerator; 0 when idle
l_k, vlr, alpha, rk, phi  out  as cmd_*  held operands to accelerator
stage_rdy  in  3  completion code from accelerator; 0 when none
done  out  1  one-cycle pulse on completion
done_stage  out  3  code of last completed stage
busy  out  1  FSM not in IDLE
q_cnt  out  clog2(DEPTH)+1  FIFO occupancy
err_illegal  out  1  one-cycle pulse: illegal code dropped
err_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (sys_rst=0 at edge): FIFO empty, FSM IDLE. stage_val, operands, done, done_stage, err_* = 0; busy=0; q_cnt=0; cmd_rdy=1 on the first cycle after reset.
- Push: a command is accepted when cmd_val & cmd_rdy. cmd_rdy is a function of q_cnt only; there is no bypass when full, even if a pop occurs in the same cycle.
- Codes 0, 5, 6, 7 are accepted but not enqueued; err_illegal pulses the next cycle.
- Push and pop in the same cycle: q_cnt is unchanged and pointers wrap mod DEPTH.
- FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: if q_cnt>0 and !flush, pop the head and go to ISSUE. On the same edge, register stage_val and all operands from the head entry.
  - Latency: command accepted at edge E0 into an empty FIFO; stage_val is valid after E1 (2-edge latency).
- ISSUE: hold stage_val for exactly PULSE_LEN cycles, then stage_val=0 and go to WAIT. stage_rdy is ignored in ISSUE.
- Operands stay stable from issue until the next issue. They are never zeroed except by reset.
- WAIT: the watchdog counts cycles from entry.
  - If stage_rdy == issued code: go to DONE. Mismatched nonzero codes are ignored.
  - If to_lim≠0 and count reaches to_lim (and no matching stage_rdy that cycle): go to ERR, set err_timeout.
  - A match and the limit in the same cycle: the match wins.
- DONE: one cycle. done=1, done_stage=issued code, then return to IDLE. Back-to-back commands therefore have ≥1 idle cycle between them.
- ERR: stage_val=0, the queue is retained and no issue occurs. Exit only on flush.
- flush (any state, highest priority below reset):
  - Next edge: FIFO emptied, FSM to IDLE, stage_val=0, err_timeout cleared.
  - A push in the same cycle as flush is discarded.
  - A completion landing in the flush cycle produces no done.
- Reset mid-operation behaves as flush and additionally zeroes all outputs.
- busy = (state≠IDLE).

Decomposition:
- Shared package (ekf_pkg): stage codes IDLE/STAGE_PRD/STAGE_NEW/STAGE_UPD/STAGE_ASSOC, a legal-code check function, and the FSM state encoding.
- One sub-module: sync_fifo (parametrised DEPTH and width; packed entry = 3+ROW_LEN+2·RSA_DW+2·RSA_AW bits; count output).
- The FSM and watchdog live in the top of the block.

Test Plan:
1. Reset, then push PRD{l_k=2, vlr=2<<19, alpha=1<<14}. Expect: stage_val=1 for 2 cycles starting 2 edges after accept, operands held. stage_rdy=1 after 10 cycles → done pulse, done_stage=1, busy=0.
2. Push PRD, NEW, UPD, ASSOC back-to-back and answer each stage_rdy after 5 cycles. Expect: issue order 1,2,3,4, exactly four done pulses, q_cnt peaks at 3.
3. Push 9 commands with DEPTH=8 while a stage is stalled. Expect: cmd_rdy=0 at q_cnt=8 and the 9th held off until the first pop, with no loss or duplication after pointer wrap.
4. Push code 6, then code 0. Expect: two err_illegal pulses, q_cnt stays 0, stage_val stays 0.
5. to_lim=20, issue UPD, never assert stage_rdy. Expect: err_timeout rises after 20 WAIT cycles and no further issue with 2 entries queued. Then flush → q_cnt=0, err_timeout=0, IDLE.
6. In WAIT for NEW, drive stage_rdy=3 then 2, and in another run assert sys_rst=0 mid-WAIT. Expect: code 3 ignored, done on code 2; reset zeroes all outputs on the next edge.

Source files
------------

// File: rtl/ekf_pkg.sv
// ---------------------------------------------------------------------------
// ekf_pkg
// Shared definitions for the EKF-SLAM stage command path.
//   stage_code_e  : stage codes placed on stage_val / stage_rdy
//   seq_state_e   : state encoding of the stage command sequencer FSM
//   is_legal_stage: true for the four codes the accelerator understands
// ---------------------------------------------------------------------------
package ekf_pkg;

   typedef enum logic [2:0] {
      STAGE_IDLE  = 3'd0,
      STAGE_PRD   = 3'd1,
      STAGE_NEW   = 3'd2,
      STAGE_UPD   = 3'd3,
      STAGE_ASSOC = 3'd4
   } stage_code_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } seq_state_e;

   // Codes 0 and 5..7 have no stage behind them and must never reach the
   // accelerator.
   function automatic logic is_legal_stage(input logic [2:0] code);
      return (code >= STAGE_PRD) && (code <= STAGE_ASSOC);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a fall-through head (rd_data always shows the oldest
// entry) and an occupancy count.
//   clk, sys_rst   : rising-edge clock, synchronous active-low reset
//   flush          : empties the FIFO on the next edge
//   push, wr_data  : write request (ignored when full)
//   pop            : removes the head entry (ignored when empty)
//   rd_data        : head entry
//   count          : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     sys_rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign wr_en   = push && (count != CW'(DEPTH));
   assign rd_en   = pop && (count != '0);
   assign rd_data = mem[rd_ptr];

   // Pointer and count bookkeeping. DEPTH is a power of two, so the pointers
   // wrap by natural overflow. A simultaneous push and pop leaves the count
   // untouched while both pointers advance.
   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (wr_en && !rd_en) begin
            count <= count + 1'b1;
         end else if (rd_en && !wr_en) begin
            count <= count - 1'b1;
         end
      end
   end

   // Storage array. It carries no reset; an entry is only ever read after
   // it has been written, because the count gates every pop.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/stage_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// stage_cmd_sequencer
// Queues stage commands for the EKF-SLAM accelerator and issues them one at
// a time: a PULSE_LEN-cycle stage_val pulse with operands held stable, then a
// wait for the matching stage_rdy code, guarded by a cycle watchdog.
//   clk, sys_rst              : rising-edge clock, sync active-low reset
//   cmd_val/cmd_rdy, cmd_*    : command push interface
//   flush                     : drop queue, abort wait, clear errors
//   to_lim                    : watchdog limit in cycles, 0 disables
//   stage_val, l_k..phi       : issued stage code and held operands
//   stage_rdy                 : completion code from the accelerator
//   done, done_stage          : completion pulse and last completed code
//   busy, q_cnt               : FSM activity and queue occupancy
//   err_illegal, err_timeout  : dropped-code pulse and sticky watchdog error
// ---------------------------------------------------------------------------
module stage_cmd_sequencer
   import ekf_pkg::*;
#(
   parameter int RSA_DW    = 32,
   parameter int RSA_AW    = 17,
   parameter int ROW_LEN   = 10,
   parameter int DEPTH     = 8,
   parameter int PULSE_LEN = 2,
   parameter int TO_W      = 16
) (
   input  logic                     clk,
   input  logic                     sys_rst,
   input  logic                     cmd_val,
   output logic                     cmd_rdy,
   input  logic [2:0]               cmd_stage,
   input  logic [ROW_LEN-1:0]       cmd_l_k,
   input  logic [RSA_DW-1:0]        cmd_vlr,
   input  logic [RSA_AW-1:0]        cmd_alpha,
   input  logic [RSA_DW-1:0]        cmd_rk,
   input  logic [RSA_AW-1:0]        cmd_phi,
   input  logic                     flush,
   input  logic [TO_W-1:0]          to_lim,
   output logic [2:0]               stage_val,
   output logic [ROW_LEN-1:0]       l_k,
   output logic [RSA_DW-1:0]        vlr,
   output logic [RSA_AW-1:0]        alpha,
   output logic [RSA_DW-1:0]        rk,
   output logic [RSA_AW-1:0]        phi,
   input  logic [2:0]               stage_rdy,
   output logic                     done,
   output logic [2:0]               done_stage,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   q_cnt,
   output logic                     err_illegal,
   output logic                     err_timeout
);

   localparam int CW      = $clog2(DEPTH) + 1;
   localparam int PW      = $clog2(PULSE_LEN + 1);
   localparam int ENTRY_W = 3 + ROW_LEN + 2 * RSA_DW + 2 * RSA_AW;

   seq_state_e          state;
   seq_state_e          state_next;

   logic [ENTRY_W-1:0]  push_entry;
   logic [ENTRY_W-1:0]  head_entry;
   logic [2:0]          head_stage;
   logic [ROW_LEN-1:0]  head_l_k;
   logic [RSA_DW-1:0]   head_vlr;
   logic [RSA_AW-1:0]   head_alpha;
   logic [RSA_DW-1:0]   head_rk;
   logic [RSA_AW-1:0]   head_phi;

   logic                accept;
   logic                legal;
   logic                push;
   logic                pop;

   logic [2:0]          cur_stage;
   logic [PW-1:0]       pulse_cnt;
   logic                pulse_last;
   logic [TO_W-1:0]     wd_cnt;
   logic [TO_W-1:0]     wd_next;
   logic                wd_expire;
   logic                rdy_match;

   // cmd_rdy looks only at the stored count, so a full queue refuses a push
   // even when a pop happens in the same cycle.
   assign cmd_rdy = (q_cnt < CW'(DEPTH));
   assign accept  = cmd_val && cmd_rdy;
   assign legal   = is_legal_stage(cmd_stage);
   assign push    = accept && legal && !flush;
   assign pop     = (state == S_IDLE) && (q_cnt != '0) && !flush;
   assign busy    = (state != S_IDLE);

   assign push_entry = {cmd_stage, cmd_l_k, cmd_vlr, cmd_alpha, cmd_rk, cmd_phi};
   assign {head_stage, head_l_k, head_vlr, head_alpha, head_rk, head_phi} = head_entry;

   // wd_cnt holds the number of WAIT cycles already completed, so wd_next is
   // the ordinal of the current WAIT cycle. A match in the limit cycle wins.
   assign pulse_last = (pulse_cnt == PW'(PULSE_LEN - 1));
   assign wd_next    = wd_cnt + 1'b1;
   assign wd_expire  = (to_lim != '0) && (wd_next == to_lim);
   assign rdy_match  = (stage_rdy == cur_stage);

   sync_fifo #(
      .DEPTH   (DEPTH),
      .WIDTH   (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .sys_rst (sys_rst),
      .flush   (flush),
      .push    (push),
      .wr_data (push_entry),
      .pop     (pop),
      .rd_data (head_entry),
      .count   (q_cnt)
   );

   // State register for the issue FSM.
   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. Flush overrides everything and returns to IDLE, which
   // is also the only way out of ERR.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (q_cnt != '0) begin
                  state_next = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (pulse_last) begin
                  state_next = S_WAIT;
               end
            end
            S_WAIT: begin
               if (rdy_match) begin
                  state_next = S_DONE;
               end else if (wd_expire) begin
                  state_next = S_ERR;
               end
            end
            S_DONE: begin
               state_next = S_IDLE;
            end
            S_ERR: begin
               state_next = S_ERR;
            end
            default: begin
               state_next = S_IDLE;
            end
         endcase
      end
   end

   // Registered outputs and counters. Operands are loaded only when a head
   // entry is popped and otherwise keep their value, so the accelerator sees
   // stable inputs until the next issue. Flush clears the strobes and the
   // errors but leaves the operands and done_stage alone.
   always_ff @(posedge clk) begin
      if (!sys_rst) begin
         stage_val   <= '0;
         l_k         <= '0;
         vlr         <= '0;
         alpha       <= '0;
         rk          <= '0;
         phi         <= '0;
         cur_stage   <= '0;
         pulse_cnt   <= '0;
         wd_cnt      <= '0;
         done        <= 1'b0;
         done_stage  <= '0;
         err_illegal <= 1'b0;
         err_timeout <= 1'b0;
      end else if (flush) begin
         stage_val   <= '0;
         pulse_cnt   <= '0;
         wd_cnt      <= '0;
         done        <= 1'b0;
         err_illegal <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         done        <= 1'b0;
         err_illegal <= accept && !legal;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  stage_val <= head_stage;
                  cur_stage <= head_stage;
                  l_k       <= head_l_k;
                  vlr       <= head_vlr;
                  alpha     <= head_alpha;
                  rk        <= head_rk;
                  phi       <= head_phi;
                  pulse_cnt <= '0;
               end
            end
            S_ISSUE: begin
               if (pulse_last) begin
                  stage_val <= '0;
                  wd_cnt    <= '0;
               end else begin
                  pulse_cnt <= pulse_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (rdy_match) begin
                  done       <= 1'b1;
                  done_stage <= cur_stage;
               end else if (wd_expire) begin
                  err_timeout <= 1'b1;
               end else begin
                  wd_cnt <= wd_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stage_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stage_cmd_sequencer
// Directed scenarios for the stage command sequencer: reset state, single
// issue timing, back-to-back ordering, full-queue hold-off and wrap, illegal
// codes, watchdog timeout and flush, match-vs-limit priority, mismatched
// completion codes and reset in the middle of a wait.
// ---------------------------------------------------------------------------
module tb_stage_cmd_sequencer;

   localparam int RSA_DW    = 32;
   localparam int RSA_AW    = 17;
   localparam int ROW_LEN   = 10;
   localparam int DEPTH     = 8;
   localparam int PULSE_LEN = 2;
   localparam int TO_W      = 16;
   localparam int CW        = $clog2(DEPTH) + 1;

   logic                clk;
   logic                sys_rst;
   logic                cmd_val;
   logic                cmd_rdy;
   logic [2:0]          cmd_stage;
   logic [ROW_LEN-1:0]  cmd_l_k;
   logic [RSA_DW-1:0]   cmd_vlr;
   logic [RSA_AW-1:0]   cmd_alpha;
   logic [RSA_DW-1:0]   cmd_rk;
   logic [RSA_AW-1:0]   cmd_phi;
   logic                flush;
   logic [TO_W-1:0]     to_lim;
   logic [2:0]          stage_val;
   logic [ROW_LEN-1:0]  l_k;
   logic [RSA_DW-1:0]   vlr;
   logic [RSA_AW-1:0]   alpha;
   logic [RSA_DW-1:0]   rk;
   logic [RSA_AW-1:0]   phi;
   logic [2:0]          stage_rdy;
   logic                done;
   logic [2:0]          done_stage;
   logic                busy;
   logic [CW-1:0]       q_cnt;
   logic                err_illegal;
   logic                err_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   stage_cmd_sequencer #(
      .RSA_DW    (RSA_DW),
      .RSA_AW    (RSA_AW),
      .ROW_LEN   (ROW_LEN),
      .DEPTH     (DEPTH),
      .PULSE_LEN (PULSE_LEN),
      .TO_W      (TO_W)
   ) dut (
      .clk         (clk),
      .sys_rst     (sys_rst),
      .cmd_val     (cmd_val),
      .cmd_rdy     (cmd_rdy),
      .cmd_stage   (cmd_stage),
      .cmd_l_k     (cmd_l_k),
      .cmd_vlr     (cmd_vlr),
      .cmd_alpha   (cmd_alpha),
      .cmd_rk      (cmd_rk),
      .cmd_phi     (cmd_phi),
      .flush       (flush),
      .to_lim      (to_lim),
      .stage_val   (stage_val),
      .l_k         (l_k),
      .vlr         (vlr),
      .alpha       (alpha),
      .rk          (rk),
      .phi         (phi),
      .stage_rdy   (stage_rdy),
      .done        (done),
      .done_stage  (done_stage),
      .busy        (busy),
      .q_cnt       (q_cnt),
      .err_illegal (err_illegal),
      .err_timeout (err_timeout)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net in case a scenario ever stops making progress.
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation still running, expected finish");
      $fatal(1, "[TB] global time limit");
   end

   // One active edge, then settle so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_cmd(input logic [2:0] st, input logic [ROW_LEN-1:0] lk,
                          input logic [RSA_DW-1:0] v, input logic [RSA_AW-1:0] a,
                          input logic [RSA_DW-1:0] r, input logic [RSA_AW-1:0] p);
      cmd_stage = st;
      cmd_l_k   = lk;
      cmd_vlr   = v;
      cmd_alpha = a;
      cmd_rk    = r;
      cmd_phi   = p;
   endtask

   task automatic test_reset();
      sys_rst = 1'b0;
      step();
      step();
      n_checks++; if (stage_val !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_stage_val: got %0d expected 0", stage_val); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
      n_checks++; if (q_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset_q_cnt: got %0d expected 0", q_cnt); end
      n_checks++; if ({done, err_illegal, err_timeout} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", {done, err_illegal, err_timeout}); end
      n_checks++; if ({l_k, vlr, alpha, rk, phi, done_stage} !== '0) begin n_fail++; $display("[TB] FAIL reset_operands: got l_k=%0d vlr=%0h done_stage=%0d expected all 0", l_k, vlr, done_stage); end
      sys_rst = 1'b1;
      step();
      n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_cmd_rdy: got %0b expected 1", cmd_rdy); end
   endtask

   task automatic test_single_prd();
      bit saw_done;
      set_cmd(3'd1, 10'd2, 32'd2 << 19, 17'd1 << 14, 32'd0, 17'd0);
      cmd_val = 1'b1;
      step();
      cmd_val = 1'b0;
      n_checks++; if (q_cnt !== 4'd1 || stage_val !== 3'd0) begin n_fail++; $display("[TB] FAIL single_accept: got q_cnt=%0d stage_val=%0d expected 1/0", q_cnt, stage_val); end
      step();
      n_checks++; if (stage_val !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL single_issue: got stage_val=%0d busy=%0b expected 1/1", stage_val, busy); end
      n_checks++; if (l_k !== 10'd2 || vlr !== 32'h0010_0000 || alpha !== 17'h04000) begin n_fail++; $display("[TB] FAIL single_operands: got l_k=%0d vlr=%0h alpha=%0h expected 2/100000/4000", l_k, vlr, alpha); end
      step();
      n_checks++; if (stage_val !== 3'd1) begin n_fail++; $display("[TB] FAIL single_pulse_2nd: got %0d expected 1", stage_val); end
      step();
      n_checks++; if (stage_val !== 3'd0 || busy !== 1'b1 || l_k !== 10'd2) begin n_fail++; $display("[TB] FAIL single_pulse_end: got stage_val=%0d busy=%0b l_k=%0d expected 0/1/2", stage_val, busy, l_k); end
      saw_done = 1'b0;
      for (int i = 0; i < 9; i++) begin
         step();
         if (done) saw_done = 1'b1;
      end
      n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("[TB] FAIL single_early_done: got done before stage_rdy, expected none"); end
      stage_rdy = 3'd1;
      step();
      stage_rdy = 3'd0;
      n_checks++; if (done !== 1'b1 || done_stage !== 3'd1) begin n_fail++; $display("[TB] FAIL single_done: got done=%0b done_stage=%0d expected 1/1", done, done_stage); end
      step();
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_idle: got done=%0b busy=%0b expected 0/0", done, busy); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] issued [8];
      logic [2:0] prev_sv;
      logic [2:0] pend;
      int n_iss;
      int done_n;
      int wait_ctr;
      int peak;
      n_iss = 0; done_n = 0; wait_ctr = 0; peak = 0; prev_sv = 3'd0; pend = 3'd0;
      set_cmd(3'd1, 10'd11, 32'd5, 17'd6, 32'd7, 17'd8);
      for (int cyc = 0; cyc < 300 && done_n < 4; cyc++) begin
         cmd_val   = (cyc < 4);
         cmd_stage = 3'(cyc + 1);
         stage_rdy = (wait_ctr == 1) ? pend : 3'd0;
         if (wait_ctr > 0) wait_ctr--;
         step();
         if (int'(q_cnt) > peak) peak = int'(q_cnt);
         if (stage_val != 3'd0 && prev_sv == 3'd0) begin
            if (n_iss < 8) issued[n_iss] = stage_val;
            n_iss++;
            pend = stage_val;
         end
         if (stage_val == 3'd0 && prev_sv != 3'd0) wait_ctr = 5;
         if (done) begin
            n_checks++; if (done_stage !== 3'(done_n + 1)) begin n_fail++; $display("[TB] FAIL b2b_done_stage: got %0d expected %0d", done_stage, done_n + 1); end
            done_n++;
         end
         prev_sv = stage_val;
      end
      cmd_val = 1'b0;
      stage_rdy = 3'd0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done) done_n++;
      end
      n_checks++; if (n_iss !== 4) begin n_fail++; $display("[TB] FAIL b2b_issue_count: got %0d expected 4", n_iss); end
      for (int i = 0; i < 4 && i < n_iss; i++) begin
         n_checks++; if (issued[i] !== 3'(i + 1)) begin n_fail++; $display("[TB] FAIL b2b_order: slot %0d got %0d expected %0d", i, issued[i], i + 1); end
      end
      n_checks++; if (done_n !== 4) begin n_fail++; $display("[TB] FAIL b2b_done_count: got %0d expected 4", done_n); end
      n_checks++; if (peak !== 3) begin n_fail++; $display("[TB] FAIL b2b_q_peak: got %0d expected 3", peak); end
   endtask

   task automatic test_fifo_full_wrap();
      logic [ROW_LEN-1:0] iss_lk [9];
      logic [2:0]         iss_code [9];
      logic [2:0]         prev_sv;
      bit pushed9;
      bit acc;
      int n_iss;
      int iss_at_push;
      set_cmd(3'd1, 10'd100, 32'd1, 17'd1, 32'd1, 17'd1);
      cmd_val = 1'b1;
      step();
      cmd_val = 1'b0;
      step(); step(); step();
      for (int i = 1; i <= 8; i++) begin
         set_cmd(3'(((i - 1) % 4) + 1), 10'(i), 32'(i * 3), 17'(i), 32'(i * 5), 17'(i));
         cmd_val = 1'b1;
         step();
      end
      n_checks++; if (q_cnt !== 4'd8 || cmd_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL full_flags: got q_cnt=%0d cmd_rdy=%0b expected 8/0", q_cnt, cmd_rdy); end
      set_cmd(3'd1, 10'd9, 32'd27, 17'd9, 32'd45, 17'd9);
      cmd_val = 1'b1;
      step(); step(); step();
      n_checks++; if (q_cnt !== 4'd8 || stage_val !== 3'd0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL full_hold: got q_cnt=%0d stage_val=%0d busy=%0b expected 8/0/1", q_cnt, stage_val, busy); end
      stage_rdy = 3'd1;
      pushed9 = 1'b0; n_iss = 0; iss_at_push = -1; prev_sv = 3'd0;
      for (int cyc = 0; cyc < 500 && !(n_iss >= 9 && !busy && pushed9); cyc++) begin
         acc = 1'b0;
         if (!pushed9) begin
            cmd_val = 1'b1;
            acc = cmd_rdy;
         end else begin
            cmd_val = 1'b0;
         end
         step();
         if (acc) begin
            pushed9 = 1'b1;
            iss_at_push = n_iss;
         end
         if (stage_val != 3'd0 && prev_sv == 3'd0) begin
            if (n_iss < 9) begin
               iss_lk[n_iss] = l_k;
               iss_code[n_iss] = stage_val;
            end
            n_iss++;
            stage_rdy = stage_val;
         end
         prev_sv = stage_val;
      end
      cmd_val = 1'b0;
      stage_rdy = 3'd0;
      n_checks++; if (iss_at_push !== 1) begin n_fail++; $display("[TB] FAIL full_ninth_accept: issues before accept got %0d expected 1", iss_at_push); end
      n_checks++; if (n_iss !== 9) begin n_fail++; $display("[TB] FAIL full_issue_count: got %0d expected 9", n_iss); end
      for (int i = 0; i < 9 && i < n_iss; i++) begin
         n_checks++;
         if (iss_lk[i] !== 10'(i + 1) || iss_code[i] !== 3'((i % 4) + 1)) begin
            n_fail++; $display("[TB] FAIL full_wrap_order: slot %0d got l_k=%0d code=%0d expected %0d/%0d", i, iss_lk[i], iss_code[i], i + 1, (i % 4) + 1);
         end
      end
      n_checks++; if (q_cnt !== '0) begin n_fail++; $display("[TB] FAIL full_drained: got q_cnt=%0d expected 0", q_cnt); end
   endtask

   task automatic test_illegal();
      set_cmd(3'd6, 10'd1, 32'd1, 17'd1, 32'd1, 17'd1);
      cmd_val = 1'b1;
      step();
      cmd_val = 1'b0;
      n_checks++; if (err_illegal !== 1'b1 || q_cnt !== '0) begin n_fail++; $display("[TB] FAIL illegal_6: got err_illegal=%0b q_cnt=%0d expected 1/0", err_illegal, q_cnt); end
      step();
      n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal_pulse_width: got %0b expected 0", err_illegal); end
      cmd_stage = 3'd0;
      cmd_val = 1'b1;
      step();
      cmd_val = 1'b0;
      n_checks++; if (err_illegal !== 1'b1 || q_cnt !== '0) begin n_fail++; $display("[TB] FAIL illegal_0: got err_illegal=%0b q_cnt=%0d expected 1/0", err_illegal, q_cnt); end
      step(); step();
      n_checks++; if (err_illegal !== 1'b0 || stage_val !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal_no_issue: got err=%0b stage_val=%0d busy=%0b expected 0/0/0", err_illegal, stage_val, busy); end
   endtask

   task automatic test_timeout_flush();
      bit saw_issue;
      to_lim = 16'd20;
      set_cmd(3'd3, 10'd5, 32'd1, 17'd1, 32'd1, 17'd1);
      cmd_val = 1'b1;
      step();
      cmd_stage = 3'd1;
      step();
      cmd_stage = 3'd2;
      step();
      cmd_val = 1'b0;
      step();
      n_checks++; if (stage_val !== 3'd0 || busy !== 1'b1 || q_cnt !== 4'd2) begin n_fail++; $display("[TB] FAIL to_wait_entry: got stage_val=%0d busy=%0b q_cnt=%0d expected 0/1/2", stage_val, busy, q_cnt); end
      for (int i = 0; i < 19; i++) step();
      n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL to_early: got err_timeout=%0b after 19 wait cycles expected 0", err_timeout); end
      step();
      n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL to_fire: got err_timeout=%0b after 20 wait cycles expected 1", err_timeout); end
      saw_issue = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (stage_val != 3'd0) saw_issue = 1'b1;
      end
      n_checks++; if (saw_issue !== 1'b0 || q_cnt !== 4'd2 || err_timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL to_err_hold: got issue=%0b q_cnt=%0d err=%0b expected 0/2/1", saw_issue, q_cnt, err_timeout); end
      flush = 1'b1;
      cmd_stage = 3'd1;
      cmd_val = 1'b1;
      step();
      flush = 1'b0;
      cmd_val = 1'b0;
      n_checks++; if (q_cnt !== '0 || err_timeout !== 1'b0 || busy !== 1'b0 || stage_val !== 3'd0) begin n_fail++; $display("[TB] FAIL flush_clear: got q_cnt=%0d err=%0b busy=%0b stage_val=%0d expected 0/0/0/0", q_cnt, err_timeout, busy, stage_val); end
      step(); step();
      n_checks++; if (q_cnt !== '0 || stage_val !== 3'd0) begin n_fail++; $display("[TB] FAIL flush_push_dropped: got q_cnt=%0d stage_val=%0d expected 0/0", q_cnt, stage_val); end
      to_lim = 16'd0;
   endtask

   task automatic test_match_beats_timeout();
      to_lim = 16'd3;
      set_cmd(3'd1, 10'd4, 32'd1, 17'd1, 32'd1, 17'd1);
      cmd_val = 1'b1;
      step();
      cmd_val = 1'b0;
      step(); step(); step();
      step(); step();
      stage_rdy = 3'd1;
      step();
      stage_rdy = 3'd0;
      n_checks++; if (done !== 1'b1 || err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL match_vs_limit: got done=%0b err_timeout=%0b expected 1/0", done, err_timeout); end
      step();
      n_checks++; if (busy !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL match_vs_limit_idle: got busy=%0b err=%0b expected 0/0", busy, err_timeout); end
      to_lim = 16'd0;
   endtask

   task automatic test_mismatch_code();
      set_cmd(3'd2, 10'd7, 32'd1, 17'd1, 32'd1, 17'd1);
      cmd_val = 1'b1;
      step();
      cmd_val = 1'b0;
      step(); step(); step();
      stage_rdy = 3'd3;
      step(); step();
      stage_rdy = 3'd4;
      step();
      n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mismatch_ignored: got done=%0b busy=%0b expected 0/1", done, busy); end
      stage_rdy = 3'd2;
      step();
      stage_rdy = 3'd0;
      n_checks++; if (done !== 1'b1 || done_stage !== 3'd2) begin n_fail++; $display("[TB] FAIL mismatch_match: got done=%0b done_stage=%0d expected 1/2", done, done_stage); end
      step();
   endtask

   task automatic test_reset_mid_wait();
      set_cmd(3'd4, 10'd9, 32'hDEAD_BEEF, 17'h1ABCD, 32'h1234_5678, 17'h0F0F0);
      cmd_val = 1'b1;
      step();
      cmd_stage = 3'd1;
      step();
      cmd_val = 1'b0;
      step(); step();
      n_checks++; if (l_k !== 10'd9 || rk !== 32'h1234_5678 || q_cnt !== 4'd1 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pre_state: got l_k=%0d rk=%0h q_cnt=%0d busy=%0b expected 9/12345678/1/1", l_k, rk, q_cnt, busy); end
      sys_rst = 1'b0;
      step();
      n_checks++; if ({stage_val, l_k, vlr, alpha, rk, phi, done_stage} !== '0) begin n_fail++; $display("[TB] FAIL rst_operands: got l_k=%0d vlr=%0h rk=%0h done_stage=%0d expected all 0", l_k, vlr, rk, done_stage); end
      n_checks++; if (busy !== 1'b0 || q_cnt !== '0 || {done, err_illegal, err_timeout} !== 3'b000) begin n_fail++; $display("[TB] FAIL rst_state: got busy=%0b q_cnt=%0d flags=%b expected 0/0/000", busy, q_cnt, {done, err_illegal, err_timeout}); end
      sys_rst = 1'b1;
      step();
      n_checks++; if (cmd_rdy !== 1'b1 || stage_val !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_release: got cmd_rdy=%0b stage_val=%0d expected 1/0", cmd_rdy, stage_val); end
   endtask

   initial begin
      sys_rst   = 1'b0;
      cmd_val   = 1'b0;
      flush     = 1'b0;
      to_lim    = 16'd0;
      stage_rdy = 3'd0;
      set_cmd(3'd0, '0, '0, '0, '0, '0);
      test_reset();
      test_single_prd();
      test_back_to_back();
      test_fifo_full_wrap();
      test_illegal();
      test_timeout_flush();
      test_match_beats_timeout();
      test_mismatch_code();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
